// File: rtl/fib_seq_source_pkg.sv
// Shared constants for the Fibonacci sequence source: default widths and FSM state encoding.
package fib_seq_source_pkg;

  localparam int unsigned FIB_WIDTH = 6;
  localparam int unsigned FIB_CNT_W = 5;
  localparam int unsigned STATE_W   = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_EMIT = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/fib_step_adder.sv
// One Fibonacci step: WIDTH-bit a+b, wrapped sum plus carry-out flagging the wrap.
module fib_step_adder
  import fib_seq_source_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum_c,
  output logic             carry_c
);

  assign {carry_c, sum_c} = (WIDTH+1)'(a) + (WIDTH+1)'(b);

endmodule

// File: rtl/fib_seq_source.sv
// Emits t[k+2] = t[k] + t[k+1] (mod 2^WIDTH), one term per out_en/out_ready handshake.
module fib_seq_source
  import fib_seq_source_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH,
  parameter int unsigned CNT_W = FIB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] f0,
  input  logic [WIDTH-1:0] f1,
  input  logic [CNT_W-1:0] n_terms,
  output logic [WIDTH-1:0] out_data,
  output logic             out_en,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_q;
  logic [WIDTH-1:0]   step_sum;
  logic               step_carry;
  logic               load;
  logic               accept;

  assign load   = (state == ST_IDLE) && start;
  assign accept = (state == ST_EMIT) && out_ready;

  fib_step_adder #(.WIDTH(WIDTH)) u_step (
    .a       (a),
    .b       (b),
    .sum_c   (step_sum),
    .carry_c (step_carry)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a zero-length run skips EMIT so cnt never underflows
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (n_terms != '0) ? ST_EMIT : ST_DONE;
        end
      end
      ST_EMIT: begin
        if (out_ready && (cnt == CNT_W'(1))) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Term registers; ovf tracks every computed sum, emitted or not
  always_ff @(posedge clk) begin
    if (rst) begin
      a     <= '0;
      b     <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (load) begin
      a     <= f0;
      b     <= f1;
      cnt   <= n_terms;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a     <= b;
      b     <= step_sum;
      cnt   <= cnt - CNT_W'(1);
      ovf_q <= ovf_q | step_carry;
    end
  end

  assign out_data = a;
  assign out_en   = (state == ST_EMIT);
  assign busy     = (state == ST_EMIT);
  assign done     = (state == ST_DONE);
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_fib_seq_source.sv
// Self-checking bench: per-cycle comparison against a term-list model, plus directed literal checks.
module tb_fib_seq_source;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] f0;
  logic [5:0] f1;
  logic [4:0] n_terms;
  logic [5:0] out_data;
  logic       out_en;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       ovf;

  fib_seq_source dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .f0        (f0),
    .f1        (f1),
    .n_terms   (n_terms),
    .out_data  (out_data),
    .out_en    (out_en),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: full term list computed up front; phase 0 idle, 1 emitting, 2 done pulse
  int   m_phase = 0;
  int   m_idx   = 0;
  int   m_n     = 0;
  int   m_t[0:33];
  bit   m_wrap[0:31];
  int   m_data  = 0;
  bit   m_ovf   = 1'b0;

  int   cap[$];
  int   busy_cnt;
  int   done_cnt;
  int   ovf_at;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_load(input int a0, input int a1, input int n);
    int s;
    m_t[0] = a0;
    m_t[1] = a1;
    for (int k = 0; k < n; k++) begin
      s = m_t[k] + m_t[k+1];
      m_wrap[k] = (s > 63);
      m_t[k+2]  = s % 64;
    end
  endfunction

  function automatic void m_step();
    if (rst) begin
      m_phase = 0; m_idx = 0; m_data = 0; m_ovf = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_n = int'(n_terms);
          m_load(int'(f0), int'(f1), m_n);
          m_idx = 0; m_data = m_t[0]; m_ovf = 1'b0;
          m_phase = (m_n != 0) ? 1 : 2;
        end
        1: if (out_ready) begin
          m_ovf  = m_ovf | m_wrap[m_idx];
          m_idx++;
          m_data = m_t[m_idx];
          if (m_idx == m_n) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  endfunction

  // One clock: record handshake, advance model at the edge, compare on the falling edge
  task automatic tick();
    if (out_en === 1'b1 && out_ready && !rst) cap.push_back(int'(out_data));
    busy_cnt += int'(busy === 1'b1);
    done_cnt += int'(done === 1'b1);
    @(posedge clk);
    m_step();
    @(negedge clk);
    chk("out_en", int'(out_en), int'(m_phase == 1));
    chk("busy",   int'(busy),   int'(m_phase == 1));
    chk("done",   int'(done),   int'(m_phase == 2));
    chk("out_data", int'(out_data), m_data);
    chk("ovf",    int'(ovf),    int'(m_ovf));
    if (ovf === 1'b1 && ovf_at < 0) ovf_at = cap.size();
  endtask

  // rmode: 0 ready high, 1 toggle 1,0,..., 2 random; poke re-asserts start mid-run
  task automatic do_run(input int a0, input int a1, input int n, input int rmode,
                        input bit poke, input int rst_at);
    int cyc;
    cap.delete();
    busy_cnt = 0; done_cnt = 0;
    rst = 1'b0; start = 1'b1;
    f0 = 6'(a0); f1 = 6'(a1); n_terms = 5'(n);
    out_ready = 1'($urandom_range(0, 1));
    tick();
    ovf_at = -1;
    start = 1'b0;
    cyc = 0;
    while (m_phase != 0 && cyc < 200) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke && cyc == 2) begin
        start = 1'b1; f0 = 6'd7; f1 = 6'd7; n_terms = 5'd3;
      end else begin
        start = 1'b0;
      end
      rst = (cyc == rst_at);
      tick();
      cyc++;
    end
    rst = 1'b0; start = 1'b0;
    if (m_phase != 0) chk("run_timeout", 1, 0);
  endtask

  task automatic chk_fib6(input string name);
    int exp6[6] = '{1, 1, 2, 3, 5, 8};
    chk({name, "_len"}, cap.size(), 6);
    for (int i = 0; i < 6 && i < cap.size(); i++) chk({name, "_term"}, cap[i], exp6[i]);
  endtask

  initial begin
    int exp3[4] = '{34, 55, 25, 16};
    rst = 1'b1; start = 1'b0; f0 = '0; f1 = '0; n_terms = '0; out_ready = 1'b0;
    ovf_at = -1; busy_cnt = 0; done_cnt = 0;
    tick();
    tick();
    chk("reset_data", int'(out_data), 0);
    chk("reset_en",   int'(out_en),   0);
    rst = 1'b0;
    tick();

    // Basic streaming run
    do_run(1, 1, 6, 0, 1'b0, -1);
    chk_fib6("t1");
    chk("t1_busy_cycles", busy_cnt, 6);
    chk("t1_done_cycles", done_cnt, 1);
    chk("t1_ovf", int'(ovf), 0);

    // Ready toggling stretches the run to 11 EMIT cycles
    do_run(1, 1, 6, 1, 1'b0, -1);
    chk_fib6("t2");
    chk("t2_busy_cycles", busy_cnt, 11);

    // Wrap past 63 after the ninth term
    do_run(1, 1, 12, 0, 1'b0, -1);
    chk("t3_len", cap.size(), 12);
    for (int i = 0; i < 4 && i + 8 < cap.size(); i++) chk("t3_term", cap[i+8], exp3[i]);
    chk("t3_ovf_after_term", ovf_at, 9);
    chk("t3_ovf", int'(ovf), 1);

    // Zero-length run
    do_run(5, 9, 0, 0, 1'b0, -1);
    chk("t4_busy_cycles", busy_cnt, 0);
    chk("t4_done_cycles", done_cnt, 1);
    chk("t4_len", cap.size(), 0);

    // start during EMIT is ignored
    do_run(1, 1, 6, 0, 1'b1, -1);
    chk_fib6("t5");

    // Reset in the middle of EMIT, then a clean run
    do_run(1, 1, 6, 0, 1'b0, 2);
    chk("t6_en_after_rst", int'(out_en), 0);
    chk("t6_data_after_rst", int'(out_data), 0);
    do_run(1, 1, 6, 0, 1'b0, -1);
    chk_fib6("t6");

    // Randomized runs
    for (int r = 0; r < 60; r++) begin
      do_run(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
             int'($urandom_range(0, 31)), 2, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20)) : -1);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
